scan_peak_finder: RTL and testbench
===================================

// Module: scan_peak_finder
// PURPOSE
//  Receive side of the ramp scanner. Consumes the scanner's ramp value and low-limit trigger,
//  plus the error/transmission signal, and characterises each scan period.
//  Per period: max and min signal values, ramp positions where they occur, contrast, period length.
//  Results feed the lock-point selection logic and the register bank (read-only regs).
// PARAMETERS
//  R        14   signal/ramp resolution, signed two's complement
//  CW       32   period counter / timeout width
// PORTS
//  clk            in   1    system clock (single clock domain)
//  rst            in   1    synchronous reset, active-high
//  scan_enable    in   1    1 = run finder; 0 = go IDLE, hold last results
//  ramp_in        in   R    signed ramp value from scanner outA
//  trigger_low    in   1    one-cycle pulse, ramp at low limit (period boundary)
//  sig_in         in   R    signed signal under test
//  timeout_cycles in   CW   max period length; 0 = timeout disabled
//  max_val        out  R    signed max of sig_in over last complete period
//  max_pos        out  R    ramp_in sample at max_val
//  min_val        out  R    signed min of sig_in over last complete period
//  min_pos        out  R    ramp_in sample at min_val
//  contrast       out  R+1  max_val - min_val, unsigned, full width, no saturation
//  period_len     out  CW   clk cycles in last complete period
//  result_valid   out  1    one-cycle pulse when result outputs update
//  timeout        out  1    sticky; set on period overrun, cleared on next result_valid or rst
//  zc_found       out  1    zero crossing detected in last period (ZERO_CROSS_EN)
//  zc_pos         out  R    ramp_in at first zero crossing (ZERO_CROSS_EN)
// BEHAVIOUR
//  - Input stage: ramp_in, trigger_low, sig_in registered together (1 cycle); all logic uses registered copies.
//  - Reset: state=IDLE; every output 0; accumulators 0; period counter 0.
//  - FSM states: IDLE, ARMED, SCAN.
//    IDLE : scan_enable=1 -> ARMED.
//    ARMED: registered trigger -> SCAN; accumulators load current sample (max=min=sig, pos=ramp), cnt=1.
//    SCAN : each cycle cnt+=1; sig>max_acc -> update max/pos; sig<min_acc -> update min/pos.
//           Strict compares: first occurrence wins ties.
//           Registered trigger -> latch results, pulse result_valid, clear timeout, re-seed accumulators
//           with current sample, cnt=1, stay SCAN (back-to-back periods, no dead cycle).
//           timeout_cycles!=0 and cnt==timeout_cycles without trigger -> timeout=1, -> ARMED, no result.
//  - Any state, scan_enable=0 -> IDLE next cycle; outputs hold; partial period discarded.
//    scan_enable fall and trigger same cycle: enable wins, no result.
//  - Latency: trigger_low at input cycle t -> result_valid and outputs updated at t+2.
//  - Counter saturates at all-ones (no wrap) when timeout disabled.
//  - contrast computed as sign-extended R+1 subtraction at latch time.
//  - sig_in/ramp_in changes with trigger low are tracked normally; ramp direction not used.
// CONFIGURATION
//  ZERO_CROSS_EN defined: per period record first sample where sign(sig) differs from previous
//    sample (prev sample reset at period start); zc_pos = ramp_in of that sample, zc_found=1;
//    both latched with other results.
//  ZERO_CROSS_EN undefined: no zero-cross logic; zc_found=0, zc_pos=0 constant; ports kept.
// STRUCTURE
//  - Shared package/include lock_scan_pkg: FSM state encoding (IDLE=2'd0, ARMED=2'd1, SCAN=2'd2),
//    default CW, R.
//  - Sub-module scan_extreme_tracker (params R, IS_MAX): value/position accumulator with seed and
//    strict-compare update; instantiated twice (max, min).
//  - Top: input register stage, FSM, period counter, result latch, optional zero-cross block.
// TESTING
//  1 rst mid-SCAN: all outputs 0, state IDLE, no result_valid until after next two triggers.
//  2 ramp -100..+100 step 1, sig=-(ramp-20)^2/8, triggers every 200 cycles -> max_val=0,
//    max_pos=20, min_pos=-100, period_len=200, result_valid at trigger+2.
//  3 sig constant 500 with two equal peaks 900 at ramp 10 and 50 -> max_pos=10 (first wins), contrast=400.
//  4 timeout_cycles=150, triggers every 200 -> timeout=1, no result_valid; set timeout_cycles=0 -> results resume,
//    timeout clears on first result_valid.
//  5 scan_enable drops same cycle as trigger -> no result_valid, outputs hold previous values.
//  6 ZERO_CROSS_EN: sig=ramp-37 -> zc_found=1, zc_pos=37; without macro zc_found=0, zc_pos=0.

Source files
------------

// File: rtl/lock_scan_pkg.sv
// lock_scan_pkg: shared constants and FSM encoding for the scan peak finder
package lock_scan_pkg;
    localparam int R_DEF = 14;
    localparam int CW_DEF = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SCAN = 2'd2} scan_state_t;
endpackage

// File: rtl/scan_peak_finder_if.sv
// scan_peak_finder_if: scanner inputs and per-period result outputs of the peak finder
interface scan_peak_finder_if import lock_scan_pkg::*; #(
    parameter int R = R_DEF,
    parameter int CW = CW_DEF
);
    logic scan_enable;
    logic signed [R-1:0] ramp_in;
    logic trigger_low;
    logic signed [R-1:0] sig_in;
    logic [CW-1:0] timeout_cycles;
    logic signed [R-1:0] max_val;
    logic signed [R-1:0] max_pos;
    logic signed [R-1:0] min_val;
    logic signed [R-1:0] min_pos;
    logic [R:0] contrast;
    logic [CW-1:0] period_len;
    logic result_valid;
    logic timeout;
    logic zc_found;
    logic signed [R-1:0] zc_pos;
    modport master (
        output scan_enable, ramp_in, trigger_low, sig_in, timeout_cycles,
        input max_val, max_pos, min_val, min_pos, contrast, period_len, result_valid, timeout, zc_found, zc_pos
    );
    modport slave (
        input scan_enable, ramp_in, trigger_low, sig_in, timeout_cycles,
        output max_val, max_pos, min_val, min_pos, contrast, period_len, result_valid, timeout, zc_found, zc_pos
    );
endinterface

// File: rtl/scan_extreme_tracker.sv
// scan_extreme_tracker: running max (IS_MAX=1) or min of sig with its position; seed restarts the period
module scan_extreme_tracker #(
    parameter int R = 14,
    parameter bit IS_MAX = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic seed,
    input  logic en,
    input  logic signed [R-1:0] sig,
    input  logic signed [R-1:0] pos,
    output logic signed [R-1:0] val,
    output logic signed [R-1:0] val_pos
);
    logic better;
    // strict compare keeps the first occurrence on ties
    assign better = IS_MAX ? (sig > val) : (sig < val);
    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
            val_pos <= '0;
        end else if (seed || (en && better)) begin
            val <= sig;
            val_pos <= pos;
        end
    end
endmodule

// File: rtl/scan_peak_finder.sv
// scan_peak_finder: per-scan-period max/min/contrast/length characterisation of the signal vs ramp.
// Optional zero-crossing capture enabled by defining ZERO_CROSS_EN.
module scan_peak_finder import lock_scan_pkg::*; #(
    parameter int R = R_DEF,
    parameter int CW = CW_DEF
) (
    input logic clk,
    input logic rst,
    scan_peak_finder_if.slave bus
);
    scan_state_t state;
    logic signed [R-1:0] ramp_r, sig_r, mx, mx_pos, mn, mn_pos, zc_p;
    logic trig_r, run, seed, track, latch, expire, zc_f;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_r <= '0;
            sig_r <= '0;
            trig_r <= 1'b0;
        end else begin
            ramp_r <= bus.ramp_in;
            sig_r <= bus.sig_in;
            trig_r <= bus.trigger_low;
        end
    end
    assign run = bus.scan_enable && (state != IDLE);
    assign seed = run && trig_r;
    assign track = run && (state == SCAN) && !trig_r;
    assign latch = seed && (state == SCAN);
    assign expire = track && (bus.timeout_cycles != '0) && (cnt == bus.timeout_cycles);
    scan_extreme_tracker #(.R(R), .IS_MAX(1'b1)) u_max (
        .clk(clk), .rst(rst), .seed(seed), .en(track), .sig(sig_r), .pos(ramp_r), .val(mx), .val_pos(mx_pos)
    );
    scan_extreme_tracker #(.R(R), .IS_MAX(1'b0)) u_min (
        .clk(clk), .rst(rst), .seed(seed), .en(track), .sig(sig_r), .pos(ramp_r), .val(mn), .val_pos(mn_pos)
    );
`ifdef ZERO_CROSS_EN
    logic prev_neg, zc_acc;
    logic signed [R-1:0] zc_pos_acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_neg <= 1'b0;
            zc_acc <= 1'b0;
            zc_pos_acc <= '0;
        end else if (seed) begin
            prev_neg <= sig_r[R-1];
            zc_acc <= 1'b0;
            zc_pos_acc <= '0;
        end else if (track) begin
            prev_neg <= sig_r[R-1];
            if (!zc_acc && (sig_r[R-1] != prev_neg)) begin
                zc_acc <= 1'b1;
                zc_pos_acc <= ramp_r;
            end
        end
    end
    assign zc_f = zc_acc;
    assign zc_p = zc_pos_acc;
`else
    assign zc_f = 1'b0;
    assign zc_p = '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bus.max_val <= '0;
            bus.max_pos <= '0;
            bus.min_val <= '0;
            bus.min_pos <= '0;
            bus.contrast <= '0;
            bus.period_len <= '0;
            bus.result_valid <= 1'b0;
            bus.timeout <= 1'b0;
            bus.zc_found <= 1'b0;
            bus.zc_pos <= '0;
        end else begin
            bus.result_valid <= latch;
            if (!bus.scan_enable) state <= IDLE;
            else if (state == IDLE) state <= ARMED;
            else if (seed) state <= SCAN;
            else if (expire) state <= ARMED;
            // the trigger sample opens the next period, so it already counts as 1
            if (seed) cnt <= CW'(1);
            else if (track && !(&cnt)) cnt <= cnt + CW'(1);
            if (expire) bus.timeout <= 1'b1;
            if (latch) begin
                bus.max_val <= mx;
                bus.max_pos <= mx_pos;
                bus.min_val <= mn;
                bus.min_pos <= mn_pos;
                bus.contrast <= {mx[R-1], mx} - {mn[R-1], mn};
                bus.period_len <= cnt;
                bus.timeout <= 1'b0;
                bus.zc_found <= zc_f;
                bus.zc_pos <= zc_p;
            end
        end
    end
endmodule

// File: tb/tb_scan_peak_finder.sv
// tb_scan_peak_finder: directed checks of reset, period statistics, ties, timeout, enable drop, zero crossing
module tb_scan_peak_finder;
`ifdef ZERO_CROSS_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int rv_cnt = 0;
    scan_peak_finder_if #(.R(14), .CW(32)) dut_if ();
    scan_peak_finder #(.R(14), .CW(32)) dut (.clk(clk), .rst(rst), .bus(dut_if.slave));
    always #5 clk = ~clk;
    always @(negedge clk) if (dut_if.result_valid === 1'b1) rv_cnt++;

    // pattern 1 rounds the parabola away from zero so its peak at ramp 20 is unique
    function automatic int sig_of(input int p, input int r);
        int d;
        d = r - 20;
        if (p == 1) return -((d * d + 7) / 8);
        if (p == 2) return (r == 10 || r == 50) ? 900 : 500;
        return r - 37;
    endfunction

    task automatic drive(input int r, input int s, input bit t);
        dut_if.ramp_in = 14'(r);
        dut_if.sig_in = 14'(s);
        dut_if.trigger_low = t;
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int p, input bit chk);
        for (int i = 0; i < 200; i++) begin
            drive(-100 + i, sig_of(p, -100 + i), i == 0);
            if (chk && i < 2) begin
                total++;
                if (dut_if.result_valid !== (i == 1)) begin
                    bad++;
                    $display("FAIL result_valid_latency i=%0d got=%b want=%b", i, dut_if.result_valid, i == 1);
                end
            end
        end
    endtask

    task automatic test_reset;
        dut_if.scan_enable = 1'b0;
        dut_if.timeout_cycles = '0;
        rst = 1'b1;
        repeat (3) drive(0, 0, 0);
        rst = 1'b0;
        total++;
        if ({dut_if.max_val, dut_if.max_pos, dut_if.min_val, dut_if.min_pos, dut_if.contrast, dut_if.period_len,
             dut_if.result_valid, dut_if.timeout, dut_if.zc_found, dut_if.zc_pos} !== '0) begin
            bad++;
            $display("FAIL reset_outputs max=%0d min=%0d len=%0d rv=%b want all zero", dut_if.max_val, dut_if.min_val,
                     dut_if.period_len, dut_if.result_valid);
        end
    endtask

    task automatic test_ramp;
        int rv0;
        rv0 = rv_cnt;
        dut_if.scan_enable = 1'b1;
        repeat (2) drive(0, 0, 0);
        period(1, 0);
        period(1, 1);
        total++;
        if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL ramp_rv_count got=%0d want=1", rv_cnt - rv0); end
        total++;
        if (dut_if.max_val !== 14'sd0) begin bad++; $display("FAIL ramp_max_val got=%0d want=0", dut_if.max_val); end
        total++;
        if (dut_if.max_pos !== 14'sd20) begin bad++; $display("FAIL ramp_max_pos got=%0d want=20", dut_if.max_pos); end
        total++;
        if (dut_if.min_val !== -14'sd1800) begin bad++; $display("FAIL ramp_min_val got=%0d want=-1800", dut_if.min_val); end
        total++;
        if (dut_if.min_pos !== -14'sd100) begin bad++; $display("FAIL ramp_min_pos got=%0d want=-100", dut_if.min_pos); end
        total++;
        if (dut_if.contrast !== 15'd1800) begin bad++; $display("FAIL ramp_contrast got=%0d want=1800", dut_if.contrast); end
        total++;
        if (dut_if.period_len !== 32'd200) begin bad++; $display("FAIL ramp_period_len got=%0d want=200", dut_if.period_len); end
    endtask

    task automatic test_rst_mid;
        int rv0;
        for (int i = 0; i < 50; i++) drive(-100 + i, sig_of(1, -100 + i), 0);
        rst = 1'b1;
        drive(0, 0, 0);
        rst = 1'b0;
        total++;
        if ({dut_if.max_val, dut_if.max_pos, dut_if.min_val, dut_if.min_pos, dut_if.contrast, dut_if.period_len,
             dut_if.result_valid, dut_if.timeout, dut_if.zc_found, dut_if.zc_pos} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs max_pos=%0d min=%0d len=%0d want all zero", dut_if.max_pos, dut_if.min_val,
                     dut_if.period_len);
        end
        rv0 = rv_cnt;
        period(1, 0);
        total++;
        if (rv_cnt !== rv0) begin bad++; $display("FAIL rst_mid_first_trigger rv_count got=%0d want=%0d", rv_cnt, rv0); end
        period(1, 1);
        total++;
        if (rv_cnt !== rv0 + 1) begin bad++; $display("FAIL rst_mid_second_trigger rv_count got=%0d want=%0d", rv_cnt, rv0 + 1); end
        total++;
        if (dut_if.max_pos !== 14'sd20) begin bad++; $display("FAIL rst_mid_max_pos got=%0d want=20", dut_if.max_pos); end
    endtask

    task automatic test_ties;
        period(2, 1);
        period(1, 1);
        total++;
        if (dut_if.max_val !== 14'sd900) begin bad++; $display("FAIL ties_max_val got=%0d want=900", dut_if.max_val); end
        total++;
        if (dut_if.max_pos !== 14'sd10) begin bad++; $display("FAIL ties_max_pos got=%0d want=10", dut_if.max_pos); end
        total++;
        if (dut_if.min_val !== 14'sd500) begin bad++; $display("FAIL ties_min_val got=%0d want=500", dut_if.min_val); end
        total++;
        if (dut_if.min_pos !== -14'sd100) begin bad++; $display("FAIL ties_min_pos got=%0d want=-100", dut_if.min_pos); end
        total++;
        if (dut_if.contrast !== 15'd400) begin bad++; $display("FAIL ties_contrast got=%0d want=400", dut_if.contrast); end
    endtask

    task automatic test_timeout;
        int rv0;
        dut_if.timeout_cycles = 32'd150;
        period(1, 1);
        total++;
        if (dut_if.timeout !== 1'b1) begin bad++; $display("FAIL timeout_set got=%b want=1", dut_if.timeout); end
        rv0 = rv_cnt;
        period(1, 0);
        total++;
        if (rv_cnt !== rv0) begin bad++; $display("FAIL timeout_no_result rv_count got=%0d want=%0d", rv_cnt, rv0); end
        total++;
        if (dut_if.timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", dut_if.timeout); end
        dut_if.timeout_cycles = '0;
        period(1, 0);
        total++;
        if (dut_if.timeout !== 1'b1) begin bad++; $display("FAIL timeout_held_until_result got=%b want=1", dut_if.timeout); end
        period(2, 1);
        total++;
        if (dut_if.timeout !== 1'b0) begin bad++; $display("FAIL timeout_cleared got=%b want=0", dut_if.timeout); end
        total++;
        if (dut_if.period_len !== 32'd200) begin bad++; $display("FAIL timeout_resume_len got=%0d want=200", dut_if.period_len); end
    endtask

    task automatic test_enable_drop;
        int rv0;
        rv0 = rv_cnt;
        dut_if.scan_enable = 1'b0;
        drive(-100, 500, 1);
        repeat (3) drive(-99, 500, 0);
        total++;
        if (rv_cnt !== rv0) begin bad++; $display("FAIL enable_drop_rv_count got=%0d want=%0d", rv_cnt, rv0); end
        total++;
        if (dut_if.max_val !== 14'sd0) begin bad++; $display("FAIL enable_drop_max_val got=%0d want=0", dut_if.max_val); end
        total++;
        if (dut_if.max_pos !== 14'sd20) begin bad++; $display("FAIL enable_drop_max_pos got=%0d want=20", dut_if.max_pos); end
    endtask

    task automatic test_zero_cross;
        dut_if.scan_enable = 1'b1;
        repeat (2) drive(0, 0, 0);
        period(3, 0);
        period(1, 1);
        total++;
        if (dut_if.max_val !== 14'sd62) begin bad++; $display("FAIL zc_max_val got=%0d want=62", dut_if.max_val); end
        total++;
        if (dut_if.min_val !== -14'sd137) begin bad++; $display("FAIL zc_min_val got=%0d want=-137", dut_if.min_val); end
        total++;
        if (dut_if.contrast !== 15'd199) begin bad++; $display("FAIL zc_contrast got=%0d want=199", dut_if.contrast); end
        total++;
        if (dut_if.zc_found !== ZC) begin bad++; $display("FAIL zc_found got=%b want=%b", dut_if.zc_found, ZC); end
        total++;
        if (dut_if.zc_pos !== (ZC ? 14'sd37 : 14'sd0)) begin
            bad++;
            $display("FAIL zc_pos got=%0d want=%0d", dut_if.zc_pos, ZC ? 37 : 0);
        end
    endtask

    initial begin
        dut_if.ramp_in = '0;
        dut_if.sig_in = '0;
        dut_if.trigger_low = 1'b0;
        test_reset();
        test_ramp();
        test_rst_mid();
        test_ties();
        test_timeout();
        test_enable_drop();
        test_zero_cross();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
